// File: rtl/dut_fifo_alu_if.sv
// dut_fifo_alu_if
//   Method-style bus for dut_fifo_alu: one write channel and one read
//   channel, each selected by an address.
//   Signals:
//     write_address, write_data, write_en : driven by master
//     write_rdy                           : driven by slave
//     read_address, read_en               : driven by master
//     read_data, read_rdy                 : driven by slave
//   Modports: master (bench / wrapper side), slave (design side).
interface dut_fifo_alu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) ();

  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [ADDR_W-1:0] read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );

endinterface

// File: rtl/dut_fifo_alu.sv
// dut_fifo_alu
//   Two operand FIFOs (A, B) feed a one-stage ALU (OR/AND/XOR/ADD, chosen
//   by a mode register). The ALU result is registered and then pushed into
//   a result FIFO (Y), which is read back through the read channel together
//   with status words.
//   Ports:
//     CLK   : clock, rising edge
//     RST_N : asynchronous active-low reset
//     bus   : dut_fifo_alu_if.slave
//       write map: 4 push A, 5 push B, 6 mode, others ignored
//       read map : 0 A not-full, 1 B not-full, 2 Y not-empty,
//                  3 Y head (pops), 6 mode, 7 Y occupancy, others 0
module dut_fifo_alu #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic           CLK,
  input  logic           RST_N,
  dut_fifo_alu_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] ADDR_A_NF  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_B_NF  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_Y_NE  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_Y_DAT = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_A_PUSH = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_B_PUSH = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_Y_CNT = ADDR_W'(7);

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  op_e mode;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];
  logic [DATA_W-1:0] y_mem [DEPTH];

  logic [PTR_W-1:0] a_wr_ptr, a_rd_ptr;
  logic [PTR_W-1:0] b_wr_ptr, b_rd_ptr;
  logic [PTR_W-1:0] y_wr_ptr, y_rd_ptr;
  logic [CNT_W-1:0] a_cnt, b_cnt, y_cnt;

  logic a_full, b_full, y_empty;
  logic push_a, push_b, wr_mode, pop_y, fire;
  logic res_valid;
  logic [DATA_W-1:0] res_data;
  logic [DATA_W-1:0] alu_out;
  logic [CNT_W:0]    y_pending;

  assign a_full  = (a_cnt == CNT_W'(DEPTH));
  assign b_full  = (b_cnt == CNT_W'(DEPTH));
  assign y_empty = (y_cnt == '0);

  // Write acceptance looks only at registered counts, so a compute pop on
  // the same edge never makes room for a push that was refused.
  always_comb begin
    bus.write_rdy = 1'b1;
    if ((bus.write_address == ADDR_A_PUSH && a_full) ||
        (bus.write_address == ADDR_B_PUSH && b_full)) begin
      bus.write_rdy = 1'b0;
    end
  end

  assign push_a  = bus.write_en && bus.write_rdy && (bus.write_address == ADDR_A_PUSH);
  assign push_b  = bus.write_en && bus.write_rdy && (bus.write_address == ADDR_B_PUSH);
  assign wr_mode = bus.write_en && bus.write_rdy && (bus.write_address == ADDR_MODE);

  assign bus.read_rdy = !((bus.read_address == ADDR_Y_DAT) && y_empty);
  assign pop_y = bus.read_en && bus.read_rdy && (bus.read_address == ADDR_Y_DAT);

  // The in-flight result is counted against Y space so Y can never overflow
  // even though the push lags the compute by one edge.
  assign y_pending = {1'b0, y_cnt} + {{CNT_W{1'b0}}, res_valid};
  assign fire = (a_cnt != '0) && (b_cnt != '0) && (y_pending < (CNT_W+1)'(DEPTH));

  always_comb begin
    case (mode)
      OP_AND:  alu_out = a_mem[a_rd_ptr] & b_mem[b_rd_ptr];
      OP_XOR:  alu_out = a_mem[a_rd_ptr] ^ b_mem[b_rd_ptr];
      OP_ADD:  alu_out = a_mem[a_rd_ptr] + b_mem[b_rd_ptr];
      default: alu_out = a_mem[a_rd_ptr] | b_mem[b_rd_ptr];
    endcase
  end

  // Storage arrays carry no reset; emptiness is defined by the counts.
  always_ff @(posedge CLK) begin
    if (push_a)    a_mem[a_wr_ptr] <= bus.write_data;
    if (push_b)    b_mem[b_wr_ptr] <= bus.write_data;
    if (res_valid) y_mem[y_wr_ptr] <= res_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_wr_ptr <= '0;
      a_rd_ptr <= '0;
      a_cnt    <= '0;
    end else begin
      if (push_a) a_wr_ptr <= a_wr_ptr + PTR_W'(1);
      if (fire)   a_rd_ptr <= a_rd_ptr + PTR_W'(1);
      case ({push_a, fire})
        2'b10:   a_cnt <= a_cnt + CNT_W'(1);
        2'b01:   a_cnt <= a_cnt - CNT_W'(1);
        default: a_cnt <= a_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_cnt    <= '0;
    end else begin
      if (push_b) b_wr_ptr <= b_wr_ptr + PTR_W'(1);
      if (fire)   b_rd_ptr <= b_rd_ptr + PTR_W'(1);
      case ({push_b, fire})
        2'b10:   b_cnt <= b_cnt + CNT_W'(1);
        2'b01:   b_cnt <= b_cnt - CNT_W'(1);
        default: b_cnt <= b_cnt;
      endcase
    end
  end

  // One-deep result stage; the op is captured with the mode at fire time,
  // so a later mode write does not affect a result already in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= fire;
      if (fire) res_data <= alu_out;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_wr_ptr <= '0;
      y_rd_ptr <= '0;
      y_cnt    <= '0;
    end else begin
      if (res_valid) y_wr_ptr <= y_wr_ptr + PTR_W'(1);
      if (pop_y)     y_rd_ptr <= y_rd_ptr + PTR_W'(1);
      case ({res_valid, pop_y})
        2'b10:   y_cnt <= y_cnt + CNT_W'(1);
        2'b01:   y_cnt <= y_cnt - CNT_W'(1);
        default: y_cnt <= y_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode <= OP_OR;
    end else if (wr_mode) begin
      mode <= op_e'(2'(bus.write_data));
    end
  end

  // Y head reads as zero while Y is empty so stale storage never leaks out.
  always_comb begin
    bus.read_data = '0;
    case (bus.read_address)
      ADDR_A_NF:  bus.read_data = DATA_W'(!a_full);
      ADDR_B_NF:  bus.read_data = DATA_W'(!b_full);
      ADDR_Y_NE:  bus.read_data = DATA_W'(!y_empty);
      ADDR_Y_DAT: bus.read_data = y_empty ? '0 : y_mem[y_rd_ptr];
      ADDR_MODE:  bus.read_data = DATA_W'(mode);
      ADDR_Y_CNT: bus.read_data = DATA_W'(y_cnt);
      default:    bus.read_data = '0;
    endcase
  end

endmodule
